// File: rtl/spi_pkt_tx_pkg.sv
// Purpose : shared types and constants for the SPI packet transmitter.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Contents: FSM state encoding, default sync byte, rd_valid timeout, divider width.
package spi_pkt_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_HDR      = 3'd2,
    ST_FETCH    = 3'd3,
    ST_WAIT_VAL = 3'd4,
    ST_SHIFT    = 3'd5,
    ST_CS_HOLD  = 3'd6,
    ST_DRAIN    = 3'd7
  } state_t;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  // Cycles (counted from the rd_en cycle) the buffer has to present rd_valid.
  localparam int RD_TIMEOUT = 8;

  // Width of the SCLK half-period divider.
  localparam int DIV_W = 8;

endpackage

// File: rtl/spi_bit_shifter.sv
// Purpose : serialises one DATA_WIDTH word MSB first as an SPI mode-0 master.
// Latency : 2*CLK_DIV*DATA_WIDTH cycles from i_start to the o_done pulse.
// Backpressure : none; i_start is ignored while a word is in flight.
// Ports: clk/rst_n clock and async active-low reset; i_start/i_data load a word;
//        o_sclk/o_mosi SPI lines; o_done one-cycle pulse with the last SCLK fall.
module spi_bit_shifter
  import spi_pkt_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_done
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic                  r_active;
  logic [DIV_W-1:0]      r_div;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_sclk;
  logic                  r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_sclk   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_active) begin
        // MOSI presents the MSB immediately; SCLK stays low for CLK_DIV cycles.
        r_active <= 1'b1;
        r_shift  <= i_data;
        r_div    <= '0;
        r_bit    <= '0;
        r_sclk   <= 1'b0;
      end else if (r_active) begin
        if (r_div == DIV_LAST) begin
          r_div  <= '0;
          r_sclk <= ~r_sclk;
          // A falling edge closes a bit: advance MOSI while SCLK is low.
          if (r_sclk) begin
            if (r_bit == BIT_LAST) begin
              r_active <= 1'b0;
              r_done   <= 1'b1;
              r_bit    <= '0;
            end else begin
              r_bit   <= r_bit + BIT_W'(1);
              r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
    end
  end

  assign o_sclk = r_sclk;
  assign o_mosi = r_shift[DATA_WIDTH-1];
  assign o_done = r_done;

endmodule

// File: rtl/spi_pkt_tx.sv
// Purpose : sends one packet (sync byte, seq, PACKAGE_SIZE buffer bytes) over SPI per pkt_ready.
// Latency : packet starts 2 cycles after pkt_ready; one byte per buffer read plus 2*CLK_DIV*DATA_WIDTH.
// Backpressure : one request is queued in a pending flag; a further request while pending sets overrun.
// Ports: pkt_ready request pulse; rd_en/rd_data/rd_valid/rd_done package buffer;
//        spi_sclk/spi_cs_n/spi_mosi SPI master; busy, seq, overrun, rd_err status.
module spi_pkt_tx
  import spi_pkt_tx_pkg::*;
#(
  parameter int         DATA_WIDTH   = 8,
  parameter int         PACKAGE_SIZE = 60,
  parameter int         CLK_DIV      = 2,
  parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pkt_ready,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  input  logic                  rd_done,
  output logic                  spi_sclk,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  output logic                  busy,
  output logic [7:0]            seq,
  output logic                  overrun,
  output logic                  rd_err
);

  localparam int BYTE_W = $clog2(PACKAGE_SIZE + 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PACKAGE_SIZE - 1);
  localparam logic [DIV_W-1:0]  HOLD_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]        WAIT_LAST = 4'(RD_TIMEOUT - 1);

  state_t                r_state;
  logic                  r_pending;
  logic                  r_rd_en;
  logic                  r_cs_n;
  logic                  r_busy;
  logic                  r_overrun;
  logic                  r_rd_err;
  logic                  r_abort;
  logic                  r_hdr_idx;
  logic                  r_start;
  logic [7:0]            r_seq;
  logic [DIV_W-1:0]      r_hold_cnt;
  logic [BYTE_W-1:0]     r_byte_cnt;
  logic [3:0]            r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_tx_byte;
  logic                  w_done;
  logic                  w_launch;

  assign w_launch = (r_state == ST_IDLE) && r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pending  <= 1'b0;
      r_rd_en    <= 1'b0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_rd_err   <= 1'b0;
      r_abort    <= 1'b0;
      r_hdr_idx  <= 1'b0;
      r_start    <= 1'b0;
      r_seq      <= '0;
      r_hold_cnt <= '0;
      r_byte_cnt <= '0;
      r_wait_cnt <= '0;
      r_tx_byte  <= '0;
    end else begin
      r_start <= 1'b0;
      r_rd_en <= 1'b0;

      // A pulse coinciding with launch becomes the next pending request.
      if (pkt_ready) begin
        if (r_pending && !w_launch) begin
          r_overrun <= 1'b1;
        end
        r_pending <= 1'b1;
      end else if (w_launch) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_pending) begin
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          r_tx_byte  <= DATA_WIDTH'(HDR_BYTE);
          r_start    <= 1'b1;
          r_hdr_idx  <= 1'b0;
          r_byte_cnt <= '0;
          r_abort    <= 1'b0;
          r_state    <= ST_HDR;
        end
        ST_HDR: begin
          if (w_done) begin
            if (!r_hdr_idx) begin
              r_tx_byte <= DATA_WIDTH'(r_seq);
              r_start   <= 1'b1;
              r_hdr_idx <= 1'b1;
            end else begin
              r_rd_en <= 1'b1;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          // r_wait_cnt counts cycles since the rd_en cycle.
          r_wait_cnt <= 4'd1;
          r_state    <= ST_WAIT_VAL;
        end
        ST_WAIT_VAL: begin
          if (rd_valid) begin
            r_tx_byte <= rd_data;
            r_start   <= 1'b1;
            r_state   <= ST_SHIFT;
          end else if (r_wait_cnt == WAIT_LAST) begin
            // Last chance missed: rd_err is visible RD_TIMEOUT cycles after rd_en.
            r_rd_err   <= 1'b1;
            r_abort    <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= ST_CS_HOLD;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        ST_SHIFT: begin
          if (w_done) begin
            if (r_byte_cnt == BYTE_LAST) begin
              r_hold_cnt <= '0;
              r_state    <= ST_CS_HOLD;
            end else begin
              r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
              r_rd_en    <= 1'b1;
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_CS_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_cs_n  <= 1'b1;
            r_state <= ST_DRAIN;
          end else begin
            r_hold_cnt <= r_hold_cnt + DIV_W'(1);
          end
        end
        ST_DRAIN: begin
          // Wait for the buffer to rewind; an abandoned packet keeps its seq.
          if (rd_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
            if (!r_abort) begin
              r_seq <= r_seq + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  spi_bit_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .CLK_DIV   (CLK_DIV)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(r_start),
    .i_data (r_tx_byte),
    .o_sclk (spi_sclk),
    .o_mosi (spi_mosi),
    .o_done (w_done)
  );

  assign rd_en    = r_rd_en;
  assign spi_cs_n = r_cs_n;
  assign busy     = r_busy;
  assign seq      = r_seq;
  assign overrun  = r_overrun;
  assign rd_err   = r_rd_err;

endmodule

// File: tb/tb_spi_pkt_tx.sv
// Purpose : checks spi_pkt_tx packets against a byte-level packet model and an SPI slave monitor.
// Latency : n/a (testbench).
// Backpressure : buffer model answers rd_en after 2 cycles unless told to withhold.
module tb_spi_pkt_tx;

  localparam int         PS  = 4;
  localparam int         CD  = 2;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pkt_ready;
  logic       rd_en;
  logic [7:0] rd_data = 8'h00;
  logic       rd_valid = 1'b0;
  logic       rd_done;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       busy;
  logic [7:0] seq;
  logic       overrun;
  logic       rd_err;

  int checks = 0;
  int failures = 0;

  // Reference model state: packet contents and expected status.
  logic [7:0] pay [PS];
  logic [7:0] seq_model = 8'h00;
  logic       ovr_exp = 1'b0;
  logic       err_exp = 1'b0;
  int         withhold_idx = -1;

  // SPI slave monitor state.
  logic       mon_cs_prev = 1'b1;
  logic [7:0] mon_shift = 8'h00;
  int         mon_nbit = 0;
  int         mon_rises = 0;
  int         last_rises = 0;
  int         frames_done = 0;
  int         cs_falls = 0;
  logic [7:0] cur_frame [$];
  logic [7:0] last_frame [$];

  spi_pkt_tx #(
    .DATA_WIDTH  (8),
    .PACKAGE_SIZE(PS),
    .CLK_DIV     (CD),
    .HDR_BYTE    (HDR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pkt_ready(pkt_ready),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_done  (rd_done),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .busy     (busy),
    .seq      (seq),
    .overrun  (overrun),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  // Package buffer: answers each rd_en with the next payload byte 2 cycles later.
  initial begin
    int rsp_cnt;
    int rd_idx;
    rsp_cnt = 0;
    rd_idx  = 0;
    forever begin
      @(posedge clk);
      #1;
      rd_valid = 1'b0;
      if (spi_cs_n !== 1'b0) begin
        rd_idx  = 0;
        rsp_cnt = 0;
      end else begin
        if (rsp_cnt > 0) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            rd_valid = 1'b1;
            rd_data  = pay[rd_idx];
            rd_idx++;
          end
        end
        if (rd_en === 1'b1 && rd_idx != withhold_idx) rsp_cnt = 2;
      end
    end
  end

  // SPI mode-0 slave: samples MOSI on SCLK rise inside each cs_n low window.
  initial begin
    forever begin
      @(posedge spi_sclk or spi_cs_n);
      if (spi_cs_n !== mon_cs_prev) begin
        mon_cs_prev = spi_cs_n;
        if (spi_cs_n === 1'b0) begin
          cur_frame.delete();
          mon_nbit  = 0;
          mon_rises = 0;
          cs_falls++;
        end else if (spi_cs_n === 1'b1) begin
          last_frame  = cur_frame;
          last_rises  = mon_rises;
          frames_done++;
        end
      end else if (spi_sclk === 1'b1 && spi_cs_n === 1'b0) begin
        mon_rises++;
        mon_shift = {mon_shift[6:0], spi_mosi};
        mon_nbit++;
        if (mon_nbit == 8) begin
          cur_frame.push_back(mon_shift);
          mon_nbit = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
  endtask

  task automatic new_payload();
    for (int i = 0; i < PS; i++) pay[i] = 8'($urandom);
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string tag);
    int n;
    n = 0;
    while (busy !== lvl && n < limit) begin
      tick();
      n++;
    end
    check(tag, busy, lvl);
  endtask

  task automatic wait_cs(input logic lvl, input int limit, input string tag);
    int n;
    n = 0;
    while (spi_cs_n !== lvl && n < limit) begin
      tick();
      n++;
    end
    check(tag, spi_cs_n, lvl);
  endtask

  // Compare the last captured frame with {HDR, seq, payload}; then advance seq.
  task automatic check_frame(input string tag);
    logic [7:0] exp_b;
    check($sformatf("%s_len", tag), last_frame.size(), PS + 2);
    check($sformatf("%s_rises", tag), last_rises, (PS + 2) * 8);
    for (int i = 0; i < PS + 2; i++) begin
      if (i == 0)      exp_b = HDR;
      else if (i == 1) exp_b = seq_model;
      else             exp_b = pay[i-2];
      if (i < last_frame.size()) check($sformatf("%s_b%0d", tag, i), last_frame[i], exp_b);
    end
    seq_model = seq_model + 8'd1;
    check($sformatf("%s_seq", tag), seq, seq_model);
    check($sformatf("%s_ovr", tag), overrun, ovr_exp);
    check($sformatf("%s_err", tag), rd_err, err_exp);
  endtask

  task automatic run_packet(input string tag);
    int cf0;
    cf0 = cs_falls;
    pulse();
    wait_busy(1'b1, 10, $sformatf("%s_busy_up", tag));
    wait_busy(1'b0, 3000, $sformatf("%s_busy_dn", tag));
    check($sformatf("%s_cs_windows", tag), cs_falls - cf0, 1);
    check_frame(tag);
  endtask

  task automatic count_rd_en(input int target, input string tag);
    int n;
    int seen;
    n = 0;
    seen = 0;
    while (seen < target && n < 3000) begin
      tick();
      if (rd_en === 1'b1) seen++;
      n++;
    end
    check(tag, seen, target);
  endtask

  initial begin
    int cf0;
    pkt_ready = 1'b0;
    rd_done   = 1'b1;
    rst_n     = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset values.
    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_sclk", spi_sclk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_seq", seq, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    check("rst_rd_err", rd_err, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Fixed payload: A5,00,11,22,33,44 in one window, seq -> 1.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    run_packet("basic");

    for (int p = 0; p < 2; p++) begin
      new_payload();
      run_packet($sformatf("rand%0d", p));
    end

    // Withheld rd_valid on the 2nd payload read.
    new_payload();
    withhold_idx = 1;
    pulse();
    count_rd_en(2, "to_err_rd_en");
    tick();
    check("to_rd_en_one_cycle", rd_en, 1'b0);
    repeat (6) tick();
    check("to_err_before", rd_err, 1'b0);
    tick();
    check("to_err_at8", rd_err, 1'b1);
    check("to_cs_hold0", spi_cs_n, 1'b0);
    tick();
    check("to_cs_hold1", spi_cs_n, 1'b0);
    tick();
    check("to_cs_rise", spi_cs_n, 1'b1);
    wait_busy(1'b0, 50, "to_busy_dn");
    check("to_seq_kept", seq, seq_model);
    check("to_rises", last_rises, 24);
    err_exp = 1'b1;
    withhold_idx = -1;
    new_payload();
    run_packet("after_err");

    // Two extra requests during one packet: overrun, one follow-up packet only.
    new_payload();
    cf0 = cs_falls;
    pulse();
    wait_busy(1'b1, 10, "ovr_busy_up");
    repeat (20) tick();
    pulse();
    check("ovr_single", overrun, 1'b0);
    repeat (20) tick();
    pulse();
    tick();
    check("ovr_set", overrun, 1'b1);
    ovr_exp = 1'b1;
    wait_busy(1'b0, 3000, "ovr_first_dn");
    check_frame("ovr_first");
    wait_busy(1'b1, 10, "ovr_second_up");
    wait_busy(1'b0, 3000, "ovr_second_dn");
    check_frame("ovr_second");
    repeat (50) tick();
    check("ovr_no_third", busy, 1'b0);
    check("ovr_windows", cs_falls - cf0, 2);

    // Reset during the 3rd payload byte.
    new_payload();
    pulse();
    count_rd_en(3, "rst_mid_rd_en");
    repeat (10) tick();
    check("rst_mid_cs_before", spi_cs_n, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs_async", spi_cs_n, 1'b1);
    check("rst_mid_sclk_async", spi_sclk, 1'b0);
    tick();
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_seq", seq, 8'h00);
    check("rst_mid_ovr", overrun, 1'b0);
    check("rst_mid_err", rd_err, 1'b0);
    check("rst_mid_rd_en", rd_en, 1'b0);
    check("rst_mid_mosi", spi_mosi, 1'b0);
    rst_n = 1'b1;
    seq_model = 8'h00;
    ovr_exp   = 1'b0;
    err_exp   = 1'b0;
    repeat (2) tick();

    // 256 packets, then the 257th carries seq byte 00.
    for (int p = 0; p < 256; p++) begin
      new_payload();
      run_packet("wrap");
    end
    new_payload();
    run_packet("pkt257");
    check("pkt257_hdr_seq", last_frame[1], 8'h00);

    // rd_done held off 5 cycles after the window closes.
    new_payload();
    rd_done = 1'b0;
    pulse();
    wait_cs(1'b0, 20, "drain_cs_low");
    wait_cs(1'b1, 3000, "drain_cs_high");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain_rd_en%0d", i), rd_en, 1'b0);
      check($sformatf("drain_busy%0d", i), busy, 1'b1);
      tick();
    end
    rd_done = 1'b1;
    check("drain_busy_at_done", busy, 1'b1);
    tick();
    check("drain_busy_after", busy, 1'b0);
    check_frame("drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_pkt_tx.md
SPI_PKT_TX -- requirements
Module: spi_pkt_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of buffer data and SPI shift word.
REQ-002 SHALL have parameter PACKAGE_SIZE, default 60, payload bytes read from the package buffer per packet.
REQ-003 SHALL have parameter CLK_DIV, default 2, clk cycles per SCLK half-period; legal range 1..255.
REQ-004 SHALL have parameter HDR_BYTE, default 8'hA5, sync byte leading every packet.
REQ-005 SHALL have port clk  in  1  sole clock.
REQ-006 SHALL have port rst_n  in  1  reset; one clock, asynchronous, active-low.
REQ-007 SHALL have port pkt_ready  in  1  one-cycle pulse: the package buffer holds a complete package.
REQ-008 SHALL have ports rd_en  out  1  buffer read request; rd_data  in  DATA_WIDTH  buffer byte; rd_valid  in  1  rd_data qualifier; rd_done  in  1  buffer-drained flag.
REQ-009 SHALL have ports spi_sclk  out  1; spi_cs_n  out  1; spi_mosi  out  1  SPI master, mode 0.
REQ-010 SHALL have ports busy  out  1  packet in progress; seq  out  8  next sequence number; overrun  out  1  sticky; rd_err  out  1  sticky.

Function
REQ-011 SHALL latch each pkt_ready pulse into a pending flag, cleared when a packet starts; a pulse while pending is already set SHALL set overrun.
REQ-012 SHALL run FSM states IDLE, CS_SETUP, HDR, FETCH, WAIT_VAL, SHIFT, CS_HOLD, DRAIN.
REQ-013 IDLE -> CS_SETUP when pending=1; spi_cs_n falls on entry; SCLK stays low for CLK_DIV cycles before the first rising edge.
REQ-014 HDR SHALL shift HDR_BYTE, then seq, MSB first; then FETCH.
REQ-015 FETCH SHALL drive rd_en high for exactly one clk cycle, then enter WAIT_VAL.
REQ-016 WAIT_VAL SHALL capture rd_data into the shift register on the first cycle with rd_valid=1 (nominal latency 2 cycles after rd_en), then enter SHIFT.
REQ-017 With no rd_valid within 8 cycles of rd_en, SHALL set rd_err and go to CS_HOLD, abandoning the packet; seq SHALL NOT increment.
REQ-018 SHIFT: each bit is 2*CLK_DIV cycles; MOSI changes with SCLK low; SCLK rises at mid-bit; SCLK ends each byte low and stays low between bytes.
REQ-019 After payload byte k<PACKAGE_SIZE SHALL return to FETCH; after byte PACKAGE_SIZE SHALL go to CS_HOLD.
REQ-020 CS_HOLD SHALL keep spi_cs_n low CLK_DIV cycles after the final falling SCLK, then raise it, then enter DRAIN.
REQ-021 DRAIN SHALL hold rd_en low until rd_done=1 (so the buffer rewinds its read pointer), then return to IDLE; rd_done already high SHALL exit in one cycle.
REQ-022 seq SHALL increment by 1 on each successful DRAIN exit, wrapping 255 -> 0.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 A packet on the wire SHALL be exactly (PACKAGE_SIZE+2)*DATA_WIDTH SCLK rising edges within one spi_cs_n low window.
REQ-025 The bit counter SHALL be ceil(log2(DATA_WIDTH+1)) bits; the byte counter SHALL be ceil(log2(PACKAGE_SIZE+1)) bits; the divider SHALL be 8 bits.

Reset
REQ-026 On rst_n low: state IDLE, pending 0, rd_en 0, spi_sclk 0, spi_cs_n 1, spi_mosi 0, busy 0, seq 0, overrun 0, rd_err 0, all counters 0.
REQ-027 Reset asserted mid-packet SHALL raise spi_cs_n immediately (asynchronously) and discard the packet.
REQ-028 overrun and rd_err SHALL clear only on reset.

Structure
REQ-029 FSM state encoding, HDR_BYTE default and the rd_valid timeout constant (8) SHALL live in the shared DAQ package.
REQ-030 SHALL instantiate one sub-module, spi_bit_shifter (divider, SCLK generation, bit counter, MOSI shift), started per byte with a done pulse.

Verification
REQ-031 PACKAGE_SIZE=4, CLK_DIV=2, buffer model returns 8'h11,22,33,44 -> MOSI bytes A5,00,11,22,33,44; 48 SCLK rises; cs_n low once; seq becomes 1.
REQ-032 rd_valid withheld after the 2nd payload rd_en -> rd_err=1 on the 8th cycle; cs_n rises after CLK_DIV cycles; seq unchanged; next pkt_ready sends a full packet.
REQ-033 Two pkt_ready pulses during one packet -> overrun=1; exactly one further packet is sent afterwards.
REQ-034 Send 256 packets -> header seq byte on packet 257 is 8'h00.
REQ-035 rst_n low during the 3rd payload byte -> cs_n=1, sclk=0 in the same cycle; all REQ-026 values hold.
REQ-036 rd_done delayed 5 cycles after the final byte -> rd_en stays 0 throughout DRAIN; busy falls the cycle after rd_done rises.
